wb_grf: RTL and testbench

- Consumer end of the M→W pipeline register: takes the W-stage bundle and produces the final write-back data.
- Load data is extended by type and byte offset.
- Commits results into the 32×32 general register file, which it owns.
- Serves D-stage reads with same-cycle W→D bypass, and keeps a retired-instruction counter.

---
 rtl/wb_grf_pkg.sv | 27 ++
 rtl/wb_grf_load_ext.sv | 52 +++++
 rtl/wb_grf.sv | 139 +++++++++++++
 tb/tb_wb_grf.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_grf_pkg.sv
// ---------------------------------------------------------------------------
// wb_grf_pkg
// Shared constants for the write-back stage and register file:
//   WD_SEL_* : write-back data source selector encodings (W_wd_sel)
//   LD_*     : load type encodings (W_ld_type)
//   PC8_OFFSET : link offset added to the W-stage PC for jal/jalr
// ---------------------------------------------------------------------------
package wb_grf_pkg;

  // Write-back data source selector
  localparam logic [2:0] WD_SEL_ALU  = 3'd0;
  localparam logic [2:0] WD_SEL_LOAD = 3'd1;
  localparam logic [2:0] WD_SEL_PC8  = 3'd2;
  localparam logic [2:0] WD_SEL_MDU  = 3'd3;
  localparam logic [2:0] WD_SEL_CP0  = 3'd4;

  // Load type
  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  // Link address offset (delay-slot architecture: return to PC+8)
  localparam logic [31:0] PC8_OFFSET = 32'd8;

endpackage

// File: rtl/wb_grf_load_ext.sv
// ---------------------------------------------------------------------------
// wb_grf_load_ext
// Purely combinational load-data extender.
// Ports:
//   raw_word [31:0] in  : word read from bridge/DM
//   byte_off [1:0]  in  : byte offset of the access (address low bits)
//   ld_type  [2:0]  in  : LD_* encoding; unknown encodings behave as lw
//   ext_word [31:0] out : selected and sign/zero-extended result
// Halfword loads use only byte_off[1]; misaligned halfwords never reach here.
// ---------------------------------------------------------------------------
module wb_grf_load_ext
  import wb_grf_pkg::*;
(
  input  logic [31:0] raw_word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  ld_type,
  output logic [31:0] ext_word
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword out of the raw word
  always_comb begin
    byte_s = 8'h00;
    case (byte_off)
      2'd0:    byte_s = raw_word[7:0];
      2'd1:    byte_s = raw_word[15:8];
      2'd2:    byte_s = raw_word[23:16];
      2'd3:    byte_s = raw_word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (byte_off[1]) begin
      half_s = raw_word[31:16];
    end else begin
      half_s = raw_word[15:0];
    end
  end

  // Extend according to load type
  always_comb begin
    ext_word = raw_word;
    case (ld_type)
      LD_LB:   ext_word = {{24{byte_s[7]}}, byte_s};
      LD_LBU:  ext_word = {24'h00_0000, byte_s};
      LD_LH:   ext_word = {{16{half_s[15]}}, half_s};
      LD_LHU:  ext_word = {16'h0000, half_s};
      default: ext_word = raw_word;
    endcase
  end

endmodule

// File: rtl/wb_grf.sv
// ---------------------------------------------------------------------------
// wb_grf
// Write-back stage plus the 32x32 general register file it owns.
// Selects the final write-back data, commits it to the register file,
// serves two D-stage read ports with same-cycle W->D bypass and counts
// retired (non-bubble) instructions.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   W_instr           : W-stage instruction, 0 = bubble (not counted)
//   W_pc              : W-stage PC (link address source)
//   W_bridge_RD       : raw load word
//   W_CP0_RD          : mfc0 data
//   W_ALU_result      : ALU result, low 2 bits = load byte offset
//   W_MDU_result      : HI/LO read data
//   W_GRF_WA          : destination register, 0 = no write
//   W_wd_sel          : WD_SEL_* source select, 5..7 give zero
//   W_ld_type         : LD_* load type
//   D_rs_addr/D_rt_addr, D_rs_data/D_rt_data : D-stage read ports
//   W_WD              : selected write-back data (forwarded to E/M)
//   retired_cnt       : retired instruction count, wraps
// Optional: define GRF_TRACE_EN to print "@pc: $reg <= data" on every
// committed write (simulation only; no logic added).
// ---------------------------------------------------------------------------
module wb_grf
  import wb_grf_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      W_instr,
  input  logic [31:0]      W_pc,
  input  logic [31:0]      W_bridge_RD,
  input  logic [31:0]      W_CP0_RD,
  input  logic [31:0]      W_ALU_result,
  input  logic [31:0]      W_MDU_result,
  input  logic [4:0]       W_GRF_WA,
  input  logic [2:0]       W_wd_sel,
  input  logic [2:0]       W_ld_type,
  input  logic [4:0]       D_rs_addr,
  input  logic [4:0]       D_rt_addr,
  output logic [31:0]      D_rs_data,
  output logic [31:0]      D_rt_data,
  output logic [31:0]      W_WD,
  output logic [CNT_W-1:0] retired_cnt
);

  logic [31:0]      regs_q [32];
  logic [31:0]      regs_d [32];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [31:0]      ld_ext_s;
  logic [31:0]      wd_s;
  logic             unused_s;

  // RESET_PC documents the boot address only
  assign unused_s = ^RESET_PC;

  wb_grf_load_ext u_load_ext (
    .raw_word (W_bridge_RD),
    .byte_off (W_ALU_result[1:0]),
    .ld_type  (W_ld_type),
    .ext_word (ld_ext_s)
  );

  // Write-back data source mux
  always_comb begin
    wd_s = 32'h0000_0000;
    case (W_wd_sel)
      WD_SEL_ALU:  wd_s = W_ALU_result;
      WD_SEL_LOAD: wd_s = ld_ext_s;
      WD_SEL_PC8:  wd_s = W_pc + PC8_OFFSET;
      WD_SEL_MDU:  wd_s = W_MDU_result;
      WD_SEL_CP0:  wd_s = W_CP0_RD;
      default:     wd_s = 32'h0000_0000;
    endcase
  end

  assign W_WD = wd_s;

  // Next-state of register array and retire counter
  always_comb begin
    regs_d = regs_q;
    if (W_GRF_WA != 5'd0) begin
      regs_d[W_GRF_WA] = wd_s;
    end else begin
      regs_d = regs_q;
    end
    if (W_instr != 32'h0000_0000) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Register array and counter state; reset blocks any write that cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'h0000_0000;
      end
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign retired_cnt = cnt_q;

  // Read ports: $0 is hard zero, matching W destination bypasses the array
  always_comb begin
    if (D_rs_addr == 5'd0) begin
      D_rs_data = 32'h0000_0000;
    end else if (D_rs_addr == W_GRF_WA) begin
      D_rs_data = wd_s;
    end else begin
      D_rs_data = regs_q[D_rs_addr];
    end
    if (D_rt_addr == 5'd0) begin
      D_rt_data = 32'h0000_0000;
    end else if (D_rt_addr == W_GRF_WA) begin
      D_rt_data = wd_s;
    end else begin
      D_rt_data = regs_q[D_rt_addr];
    end
  end

`ifdef GRF_TRACE_EN
  // Judge trace of every committed register write
  always_ff @(posedge clk) begin
    if (!reset && (W_GRF_WA != 5'd0)) begin
      $display("@%h: $%d <= %h", W_pc, W_GRF_WA, wd_s);
    end
  end
`endif

endmodule

// File: tb/tb_wb_grf.sv
module tb_wb_grf;
  import wb_grf_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] W_instr, W_pc, W_bridge_RD, W_CP0_RD, W_ALU_result, W_MDU_result;
  logic [4:0]  W_GRF_WA, D_rs_addr, D_rt_addr;
  logic [2:0]  W_wd_sel, W_ld_type;
  logic [31:0] D_rs_data, D_rt_data, W_WD;
  logic [31:0] retired_cnt;
  logic [31:0] s_rs_data, s_rt_data, s_wd;
  logic [2:0]  s_cnt;

  int passed = 0;
  int total  = 0;

  wb_grf dut (
    .clk(clk), .reset(reset), .W_instr(W_instr), .W_pc(W_pc),
    .W_bridge_RD(W_bridge_RD), .W_CP0_RD(W_CP0_RD), .W_ALU_result(W_ALU_result),
    .W_MDU_result(W_MDU_result), .W_GRF_WA(W_GRF_WA), .W_wd_sel(W_wd_sel),
    .W_ld_type(W_ld_type), .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_rs_data(D_rs_data), .D_rt_data(D_rt_data), .W_WD(W_WD),
    .retired_cnt(retired_cnt)
  );

  // Narrow-counter instance so the wrap can be reached in a few cycles
  wb_grf #(.CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .W_instr(W_instr), .W_pc(W_pc),
    .W_bridge_RD(W_bridge_RD), .W_CP0_RD(W_CP0_RD), .W_ALU_result(W_ALU_result),
    .W_MDU_result(W_MDU_result), .W_GRF_WA(W_GRF_WA), .W_wd_sel(W_wd_sel),
    .W_ld_type(W_ld_type), .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_rs_data(s_rs_data), .D_rt_data(s_rt_data), .W_WD(s_wd),
    .retired_cnt(s_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_w(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rd, input logic [31:0] cp0,
                       input logic [31:0] alu, input logic [31:0] mdu,
                       input logic [4:0] wa, input logic [2:0] sel,
                       input logic [2:0] ld);
    W_instr = instr; W_pc = pc; W_bridge_RD = rd; W_CP0_RD = cp0;
    W_ALU_result = alu; W_MDU_result = mdu; W_GRF_WA = wa;
    W_wd_sel = sel; W_ld_type = ld;
  endtask

  task automatic set_idle();
    set_w(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, WD_SEL_ALU, LD_LW);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    D_rs_addr = 5'd0; D_rt_addr = 5'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 1; i < 32; i++) begin
      D_rs_addr = 5'(i);
      D_rt_addr = 5'(32 - i);
      #1;
      total++; if (D_rs_data !== 32'h0) $display("FAIL reset_rs[%0d]: got %h want 00000000", i, D_rs_data); else passed++;
      total++; if (D_rt_data !== 32'h0) $display("FAIL reset_rt[%0d]: got %h want 00000000", 32 - i, D_rt_data); else passed++;
    end
    total++; if (retired_cnt !== 32'h0) $display("FAIL reset_cnt: got %h want 00000000", retired_cnt); else passed++;
  endtask

  task automatic test_bypass();
    @(posedge clk); #1;
    set_w(32'h0000_0001, 32'h0000_3000, 32'h0, 32'h0, 32'h1234_5678, 32'h0, 5'd5, WD_SEL_ALU, LD_LW);
    D_rs_addr = 5'd5; D_rt_addr = 5'd5;
    #1;
    total++; if (D_rs_data !== 32'h1234_5678) $display("FAIL bypass_rs: got %h want 12345678", D_rs_data); else passed++;
    total++; if (D_rt_data !== 32'h1234_5678) $display("FAIL bypass_rt: got %h want 12345678", D_rt_data); else passed++;
    total++; if (W_WD !== 32'h1234_5678) $display("FAIL bypass_wd: got %h want 12345678", W_WD); else passed++;
    @(posedge clk); #1;
    set_idle();
    #1;
    total++; if (D_rs_data !== 32'h1234_5678) $display("FAIL array_rs5: got %h want 12345678", D_rs_data); else passed++;
  endtask

  task automatic test_load();
    set_w(32'h0, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0000_0003, 32'h0, 5'd0, WD_SEL_LOAD, LD_LB);
    #1; total++; if (W_WD !== 32'hFFFF_FF80) $display("FAIL lb_off3: got %h want ffffff80", W_WD); else passed++;
    W_ld_type = LD_LBU;
    #1; total++; if (W_WD !== 32'h0000_0080) $display("FAIL lbu_off3: got %h want 00000080", W_WD); else passed++;
    W_ALU_result = 32'h0000_0002; W_ld_type = LD_LH;
    #1; total++; if (W_WD !== 32'hFFFF_80FF) $display("FAIL lh_off2: got %h want ffff80ff", W_WD); else passed++;
    W_ld_type = LD_LHU;
    #1; total++; if (W_WD !== 32'h0000_80FF) $display("FAIL lhu_off2: got %h want 000080ff", W_WD); else passed++;
    W_ALU_result = 32'h0000_0003; W_ld_type = LD_LH;
    #1; total++; if (W_WD !== 32'hFFFF_80FF) $display("FAIL lh_off3: got %h want ffff80ff", W_WD); else passed++;
    W_ALU_result = 32'h0000_0001; W_ld_type = LD_LB;
    #1; total++; if (W_WD !== 32'h0000_007F) $display("FAIL lb_off1: got %h want 0000007f", W_WD); else passed++;
    W_ALU_result = 32'h0000_0000;
    #1; total++; if (W_WD !== 32'h0000_0001) $display("FAIL lb_off0: got %h want 00000001", W_WD); else passed++;
    W_ALU_result = 32'h0000_0001; W_ld_type = LD_LH;
    #1; total++; if (W_WD !== 32'h0000_7F01) $display("FAIL lh_off1: got %h want 00007f01", W_WD); else passed++;
    W_ld_type = LD_LW;
    #1; total++; if (W_WD !== 32'h80FF_7F01) $display("FAIL lw: got %h want 80ff7f01", W_WD); else passed++;
    W_ld_type = 3'd7;
    #1; total++; if (W_WD !== 32'h80FF_7F01) $display("FAIL ld_type7: got %h want 80ff7f01", W_WD); else passed++;
  endtask

  task automatic test_zero_reg();
    @(posedge clk); #1;
    set_w(32'h0, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd0, WD_SEL_ALU, LD_LW);
    D_rs_addr = 5'd0; D_rt_addr = 5'd5;
    #1;
    total++; if (D_rs_data !== 32'h0) $display("FAIL zero_nobypass: got %h want 00000000", D_rs_data); else passed++;
    total++; if (W_WD !== 32'hDEAD_BEEF) $display("FAIL zero_wd: got %h want deadbeef", W_WD); else passed++;
    @(posedge clk); #1;
    set_idle();
    #1;
    total++; if (D_rs_data !== 32'h0) $display("FAIL zero_after: got %h want 00000000", D_rs_data); else passed++;
    total++; if (D_rt_data !== 32'h1234_5678) $display("FAIL r5_kept: got %h want 12345678", D_rt_data); else passed++;
  endtask

  task automatic test_paths();
    @(posedge clk); #1;
    set_w(32'h0C00_0C01, 32'h0000_3004, 32'h0, 32'h0, 32'h0, 32'h0, 5'd31, WD_SEL_PC8, LD_LW);
    D_rs_addr = 5'd31; D_rt_addr = 5'd2;
    #1; total++; if (D_rs_data !== 32'h0000_300C) $display("FAIL jal_bypass: got %h want 0000300c", D_rs_data); else passed++;
    @(posedge clk); #1;
    set_w(32'h4002_6000, 32'h0000_3008, 32'h0, 32'h0000_0010, 32'h0, 32'h0, 5'd2, WD_SEL_CP0, LD_LW);
    #1;
    total++; if (D_rs_data !== 32'h0000_300C) $display("FAIL jal_array: got %h want 0000300c", D_rs_data); else passed++;
    total++; if (D_rt_data !== 32'h0000_0010) $display("FAIL mfc0_bypass: got %h want 00000010", D_rt_data); else passed++;
    @(posedge clk); #1;
    set_w(32'h0000_1810, 32'h0000_300C, 32'h0, 32'h0, 32'h0, 32'hCAFE_F00D, 5'd3, WD_SEL_MDU, LD_LW);
    D_rs_addr = 5'd3;
    #1; total++; if (W_WD !== 32'hCAFE_F00D) $display("FAIL mdu_wd: got %h want cafef00d", W_WD); else passed++;
    @(posedge clk); #1;
    set_w(32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h1111_1111, 32'h0, 5'd0, WD_SEL_PC8, LD_LW);
    #1;
    total++; if (D_rs_data !== 32'hCAFE_F00D) $display("FAIL mdu_array: got %h want cafef00d", D_rs_data); else passed++;
    total++; if (D_rt_data !== 32'h0000_0010) $display("FAIL mfc0_array: got %h want 00000010", D_rt_data); else passed++;
    total++; if (W_WD !== 32'h0000_0004) $display("FAIL pc8_wrap: got %h want 00000004", W_WD); else passed++;
    W_wd_sel = 3'd5;
    #1; total++; if (W_WD !== 32'h0) $display("FAIL sel5_zero: got %h want 00000000", W_WD); else passed++;
    W_wd_sel = 3'd7;
    #1; total++; if (W_WD !== 32'h0) $display("FAIL sel7_zero: got %h want 00000000", W_WD); else passed++;
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    set_idle();
    D_rs_addr = 5'd31; D_rt_addr = 5'd5;
    #1; total++; if (retired_cnt !== 32'd4) $display("FAIL cnt_before_rst: got %0d want 4", retired_cnt); else passed++;
    #1 reset = 1'b1;
    #1;
    total++; if (D_rs_data !== 32'h0) $display("FAIL async_r31: got %h want 00000000", D_rs_data); else passed++;
    total++; if (D_rt_data !== 32'h0) $display("FAIL async_r5: got %h want 00000000", D_rt_data); else passed++;
    total++; if (retired_cnt !== 32'h0) $display("FAIL async_cnt: got %0d want 0", retired_cnt); else passed++;
    // write attempt across an edge while reset is still high
    set_w(32'h0000_0001, 32'h0000_3010, 32'h0, 32'h0, 32'h5555_AAAA, 32'h0, 5'd9, WD_SEL_ALU, LD_LW);
    @(posedge clk); #1;
    reset = 1'b0;
    set_idle();
    D_rs_addr = 5'd9;
    #1;
    total++; if (D_rs_data !== 32'h0) $display("FAIL no_write_in_reset: got %h want 00000000", D_rs_data); else passed++;
    total++; if (retired_cnt !== 32'h0) $display("FAIL no_count_in_reset: got %0d want 0", retired_cnt); else passed++;
  endtask

  task automatic test_retire();
    logic [31:0] seq [8];
    seq = '{32'h0000_0001, 32'h2402_0005, 32'h0000_0020, 32'h0, 32'h1000_FFFF,
            32'h0000_0002, 32'h0000_0003, 32'h0000_0004};
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      W_instr = seq[i];
      @(posedge clk); #1;
    end
    W_instr = 32'h0;
    #1;
    total++; if (retired_cnt !== 32'd4) $display("FAIL retire_4: got %0d want 4", retired_cnt); else passed++;
    total++; if (s_cnt !== 3'd4) $display("FAIL retire_small_4: got %0d want 4", s_cnt); else passed++;
    for (int i = 5; i < 8; i++) begin
      W_instr = seq[i];
      @(posedge clk); #1;
    end
    W_instr = 32'h0;
    #1;
    total++; if (s_cnt !== 3'd7) $display("FAIL retire_small_7: got %0d want 7", s_cnt); else passed++;
    W_instr = 32'h0000_0009;
    @(posedge clk); #1;
    W_instr = 32'h0;
    #1;
    total++; if (s_cnt !== 3'd0) $display("FAIL retire_wrap: got %0d want 0", s_cnt); else passed++;
    total++; if (retired_cnt !== 32'd8) $display("FAIL retire_8: got %0d want 8", retired_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_load();
    test_zero_reg();
    test_paths();
    test_async_reset();
    test_retire();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
